// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS-I subset core with a unified req/ready memory port
//
// Purpose: executes add/sub/and/or/slt, lw, sw, beq, addi and j. Each instruction
// steps through FETCH, DECODE, EXECUTE, MEM and WRITEBACK over several clocks and
// shares one instruction/data memory port. An illegal opcode/funct or a misaligned
// load/store parks the core in HALT until reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   mem_req      request; held high until mem_ready accepts it
//   mem_we       1 = store, 0 = fetch/load
//   mem_addr     byte address (always word aligned)
//   mem_wdata    store data
//   mem_rdata    read data, valid in the cycle mem_ready=1
//   mem_ready    transfer completes on an edge where mem_req & mem_ready
//   halted       core stopped on a fault
//   retire_*     (MIPS_MC_RETIRE_PORT_EN only) retire pulse, its PC and a saturating count
//
// Build option: define MIPS_MC_RETIRE_PORT_EN to add the retire_valid/retire_pc/retire_count outputs.
// ADDR_WIDTH is expected to lie in 28..32 (the jump target keeps PC bits above 27).

module mips_multicycle_core #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  halted
`ifdef MIPS_MC_RETIRE_PORT_EN
  ,
  output logic                  retire_valid,
  output logic [ADDR_WIDTH-1:0] retire_pc,
  output logic [31:0]           retire_count
`endif
);

  localparam int RW = $clog2(NUM_REGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_target;
  logic [31:0]           r_ir;
  logic [31:0]           r_a;
  logic [31:0]           r_b;
  logic [31:0]           r_alu;
  logic [31:0]           r_mdr;
  logic [31:0]           r_regs [NUM_REGS];
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_halted;

  // Instruction fields
  logic [5:0]            w_op;
  logic [5:0]            w_funct;
  logic [RW-1:0]         w_rs;
  logic [RW-1:0]         w_rt;
  logic [RW-1:0]         w_rd;
  logic [31:0]           w_sext;
  logic                  w_is_r;
  logic                  w_is_lw;
  logic                  w_is_sw;
  logic                  w_is_beq;
  logic                  w_is_addi;
  logic                  w_is_j;
  logic                  w_r_legal;
  logic                  w_legal;

  // Datapath
  logic [31:0]           w_alu;
  logic [31:0]           w_ea;
  logic [31:0]           w_br_off;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_jump;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [RW-1:0]         w_wb_idx;
  logic [31:0]           w_wb_data;

  assign w_op      = r_ir[31:26];
  assign w_funct   = r_ir[5:0];
  assign w_rs      = r_ir[21 +: RW];
  assign w_rt      = r_ir[16 +: RW];
  assign w_rd      = r_ir[11 +: RW];
  assign w_sext    = {{16{r_ir[15]}}, r_ir[15:0]};

  assign w_is_r    = (w_op == OP_RTYPE);
  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_addi = (w_op == OP_ADDI);
  assign w_is_j    = (w_op == OP_J);
  assign w_r_legal = (w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                     (w_funct == FN_OR)  || (w_funct == FN_SLT);
  assign w_legal   = (w_is_r && w_r_legal) || w_is_lw || w_is_sw || w_is_beq ||
                     w_is_addi || w_is_j;

  always_comb begin
    w_alu = r_a + w_sext;
    if (w_is_r) begin
      case (w_funct)
        FN_SUB:  w_alu = r_a - r_b;
        FN_AND:  w_alu = r_a & r_b;
        FN_OR:   w_alu = r_a | r_b;
        FN_SLT:  w_alu = {31'b0, ($signed(r_a) < $signed(r_b))};
        default: w_alu = r_a + r_b;
      endcase
    end
  end

  assign w_ea      = r_a + w_sext;
  assign w_br_off  = {w_sext[29:0], 2'b00};
  // r_pc already points past the branch when DECODE computes the target.
  assign w_target  = r_pc + w_br_off[ADDR_WIDTH-1:0];
  assign w_pc_next = r_pc + ADDR_WIDTH'(4);

  always_comb begin
    w_jump       = r_pc;
    w_jump[27:0] = {r_ir[25:0], 2'b00};
  end

  assign w_wb_idx  = w_is_r ? w_rd : w_rt;
  assign w_wb_data = w_is_lw ? r_mdr : r_alu;

`ifdef MIPS_MC_RETIRE_PORT_EN
  logic [ADDR_WIDTH-1:0] r_ipc;
  logic [31:0]           r_retire_count;
  logic                  w_retire;

  // The last state of each instruction; a sw only retires on the accepting cycle.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_EXECUTE: w_retire = w_is_beq || w_is_j;
      S_MEM:     w_retire = w_is_sw && mem_ready;
      S_WB:      w_retire = 1'b1;
      default:   w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_count <= '0;
    end else if (w_retire && (r_retire_count != 32'hFFFF_FFFF)) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign retire_valid = w_retire;
  assign retire_pc    = r_ipc;
  assign retire_count = r_retire_count;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_target    <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_alu       <= '0;
      r_mdr       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_halted    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
`ifdef MIPS_MC_RETIRE_PORT_EN
      r_ipc       <= '0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          // Only reached with mem_req low straight after reset; every other
          // path into FETCH raises the request on the way in.
          if (!r_mem_req) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= r_pc;
            r_mem_wdata <= '0;
          end else if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_ir      <= mem_rdata;
            r_pc      <= w_pc_next;
`ifdef MIPS_MC_RETIRE_PORT_EN
            r_ipc     <= r_pc;
`endif
            r_state   <= S_DECODE;
          end
        end

        S_DECODE: begin
          r_a      <= (w_rs == '0) ? 32'd0 : r_regs[w_rs];
          r_b      <= (w_rt == '0) ? 32'd0 : r_regs[w_rt];
          r_target <= w_target;
          if (!w_legal) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_state  <= S_EXECUTE;
          end
        end

        S_EXECUTE: begin
          if (w_is_lw || w_is_sw) begin
            if (w_ea[1:0] != 2'b00) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_sw;
              r_mem_addr  <= w_ea[ADDR_WIDTH-1:0];
              r_mem_wdata <= w_is_sw ? r_b : 32'd0;
              r_state     <= S_MEM;
            end
          end else if (w_is_beq) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_state     <= S_FETCH;
            if (r_a == r_b) begin
              r_pc       <= r_target;
              r_mem_addr <= r_target;
            end else begin
              r_mem_addr <= r_pc;
            end
          end else if (w_is_j) begin
            r_pc        <= w_jump;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= w_jump;
            r_mem_wdata <= '0;
            r_state     <= S_FETCH;
          end else begin
            r_alu   <= w_alu;
            r_state <= S_WB;
          end
        end

        S_MEM: begin
          if (mem_ready) begin
            if (w_is_lw) begin
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_mdr     <= mem_rdata;
              r_state   <= S_WB;
            end else begin
              // Store done: go straight into the next fetch request.
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= r_pc;
              r_mem_wdata <= '0;
              r_state     <= S_FETCH;
            end
          end
        end

        S_WB: begin
          if (w_wb_idx != '0) begin
            r_regs[w_wb_idx] <= w_wb_data;
          end
          r_mem_req   <= 1'b1;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= r_pc;
          r_mem_wdata <= '0;
          r_state     <= S_FETCH;
        end

        S_HALT: begin
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
        end

        default: begin
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
          r_state   <= S_HALT;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign halted    = r_halted;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - directed-vector bench for mips_multicycle_core

module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b0;
  logic        halted;
`ifdef MIPS_MC_RETIRE_PORT_EN
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_count;
`endif

  mips_multicycle_core #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0),
    .NUM_REGS  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .halted      (halted)
`ifdef MIPS_MC_RETIRE_PORT_EN
    ,
    .retire_valid(retire_valid),
    .retire_pc   (retire_pc),
    .retire_count(retire_count)
`endif
  );

  initial forever #5 clk = ~clk;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic [31:0] mem_arr [0:255];
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int wait_n = 0;
  int wcnt = 0;
  int n_tr = 0;
  int n_st = 0;
  int stable_err = 0;
  logic [31:0] t_addr [0:255];
  logic        t_we   [0:255];
  int          t_cyc  [0:255];
  logic [31:0] t_rc   [0:255];
  logic [31:0] st_addr [0:63];
  logic [31:0] st_data [0:63];
  logic        prev_wait = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: wait_n wait cycles per access, logs every accepted transfer.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      mem_ready = 1'b0;
      wcnt      = 0;
      prev_wait = 1'b0;
    end else if (mem_req) begin
      if (prev_wait && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
        stable_err++;
      if (wcnt < wait_n) begin
        mem_ready = 1'b0;
        wcnt++;
        prev_wait = 1'b1;
        p_addr    = mem_addr;
        p_we      = mem_we;
        p_wdata   = mem_wdata;
      end else begin
        mem_ready = 1'b1;
        wcnt      = 0;
        prev_wait = 1'b0;
        if (n_tr < 256) begin
          t_addr[n_tr] = mem_addr;
          t_we[n_tr]   = mem_we;
          t_cyc[n_tr]  = cyc;
`ifdef MIPS_MC_RETIRE_PORT_EN
          t_rc[n_tr]   = retire_count;
`else
          t_rc[n_tr]   = 32'd0;
`endif
        end
        n_tr++;
        if (mem_we) begin
          mem_arr[mem_addr[9:2]] = mem_wdata;
          if (n_st < 64) begin
            st_addr[n_st] = mem_addr;
            st_data[n_st] = mem_wdata;
          end
          n_st++;
        end
      end
    end else begin
      mem_ready = 1'b0;
      wcnt      = 0;
      prev_wait = 1'b0;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  function automatic int fetch_idx(input logic [31:0] a);
    for (int i = 0; i < n_tr && i < 256; i++)
      if (!t_we[i] && t_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic int fetch_cyc(input logic [31:0] a);
    int k;
    k = fetch_idx(a);
    if (k < 0) return -1000;
    return t_cyc[k];
  endfunction

  function automatic logic [31:0] next_after(input logic [31:0] a);
    int k;
    k = fetch_idx(a);
    if (k < 0 || k + 1 >= n_tr) return 32'hDEAD_BEEF;
    return t_addr[k+1];
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst        = 1'b1;
    n_tr       = 0;
    n_st       = 0;
    stable_err = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic run_halt(input string tag);
    int k;
    k = 0;
    while (!halted && k < 500) begin
      @(posedge clk); #2;
      k++;
    end
    chk(tag, {31'b0, halted}, 32'd1);
  endtask

  task automatic quiet(input string tag);
    int cnt;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #2;
      if (mem_req) cnt++;
    end
    chk(tag, cnt, 32'd0);
  endtask

  int d;
  int k;

  initial begin
    clear_mem();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req",    {31'b0, mem_req}, 32'd0);
    chk("rst_we",     {31'b0, mem_we},  32'd0);
    chk("rst_addr",   mem_addr,         32'd0);
    chk("rst_wdata",  mem_wdata,        32'd0);
    chk("rst_halted", {31'b0, halted},  32'd0);

    // ALU program
    mem_arr[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem_arr[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem_arr[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem_arr[3]  = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
    mem_arr[4]  = enc_r(5'd0, 5'd1, 5'd5, 6'h22);
    mem_arr[5]  = enc_r(5'd1, 5'd2, 5'd6, 6'h24);
    mem_arr[6]  = enc_r(5'd1, 5'd2, 5'd7, 6'h25);
    mem_arr[7]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0100);
    mem_arr[8]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0104);
    mem_arr[9]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h0108);
    mem_arr[10] = enc_i(6'h2B, 5'd0, 5'd6, 16'h010C);
    mem_arr[11] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0110);
    mem_arr[12] = HALT_W;

    // Reset in the middle of a stalled fetch
    wait_n = 3;
    @(posedge clk); #2;
    rst = 1'b0;
    k = 0;
    while (!mem_req && k < 10) begin
      @(posedge clk); #2;
      k++;
    end
    chk("req_rise", {31'b0, mem_req}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_req",  {31'b0, mem_req}, 32'd0);
    chk("midrst_addr", mem_addr,         32'd0);
    chk("midrst_ntr",  n_tr,             32'd0);
    wait_n = 0;
    n_tr = 0;
    n_st = 0;
    stable_err = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    run_halt("alu_halt");
    chk("first_fetch", t_addr[0], 32'd0);
    d = fetch_cyc(32'h14) - fetch_cyc(32'h00);
    chk("alu_cycles", d, 32'd20);
    chk("alu_nst", n_st, 32'd5);
    chk("r3_addr", st_addr[0], 32'h100);
    chk("r3",      st_data[0], 32'd2);
    chk("r4",      st_data[1], 32'd1);
    chk("r5",      st_data[2], 32'hFFFF_FFFB);
    chk("r6_and",  st_data[3], 32'd5);
    chk("r7_or",   st_data[4], 32'hFFFF_FFFD);

    // Memory program with 2 wait cycles per access; starts with a jump so the
    // data word at 0x08 does not overlay code.
    clear_mem();
    mem_arr[0]  = enc_j(26'h20);
    mem_arr[32] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem_arr[33] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    mem_arr[34] = enc_i(6'h23, 5'd0, 5'd6, 16'd8);
    mem_arr[35] = enc_i(6'h2B, 5'd0, 5'd6, 16'h40);
    mem_arr[36] = HALT_W;
    wait_n = 2;
    do_reset();
    run_halt("mem_halt");
    chk("sw_addr",   st_addr[0], 32'd8);
    chk("sw_wdata",  st_data[0], 32'd5);
    chk("r6_addr",   st_addr[1], 32'h40);
    chk("r6_lw",     st_data[1], 32'd5);
    chk("stable",    stable_err, 32'd0);
    d = fetch_cyc(32'h88) - fetch_cyc(32'h84);
    chk("sw_cycles", d, 32'd8);
    d = fetch_cyc(32'h8C) - fetch_cyc(32'h88);
    chk("lw_cycles", d, 32'd9);

    // Control flow
    clear_mem();
    wait_n = 0;
    mem_arr[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem_arr[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
    mem_arr[2]  = enc_r(5'd0, 5'd0, 5'd0, 6'h20);
    mem_arr[3]  = enc_r(5'd0, 5'd0, 5'd0, 6'h20);
    mem_arr[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    mem_arr[5]  = HALT_W;
    mem_arr[6]  = HALT_W;
    mem_arr[7]  = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
    mem_arr[8]  = enc_j(26'h40);
    mem_arr[9]  = HALT_W;
    mem_arr[64] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0200);
    mem_arr[65] = HALT_W;
    do_reset();
    run_halt("cf_halt");
    chk("beq_taken",   next_after(32'h10), 32'h1C);
    chk("beq_nottkn",  next_after(32'h1C), 32'h20);
    chk("j_target",    next_after(32'h20), 32'h100);
    d = fetch_cyc(32'h1C) - fetch_cyc(32'h10);
    chk("beq_cycles",  d, 32'd3);
    d = fetch_cyc(32'h100) - fetch_cyc(32'h20);
    chk("j_cycles",    d, 32'd3);
    chk("cf_store",    st_data[0], 32'd5);

    // Misaligned load
    clear_mem();
    mem_arr[0] = enc_i(6'h23, 5'd0, 5'd1, 16'd2);
    do_reset();
    run_halt("mis_halt");
    chk("mis_ntr", n_tr, 32'd1);
    quiet("mis_quiet");

    // Illegal opcode
    clear_mem();
    mem_arr[0] = HALT_W;
    do_reset();
    run_halt("ill_halt");
    chk("ill_ntr", n_tr, 32'd1);
    quiet("ill_quiet");

    // Writes to r0 are discarded
    clear_mem();
    mem_arr[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    mem_arr[1] = enc_r(5'd0, 5'd0, 5'd1, 6'h20);
    mem_arr[2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h40);
    mem_arr[3] = HALT_W;
    do_reset();
    run_halt("r0_halt");
    chk("r0_addr", st_addr[0], 32'h40);
    chk("r1_zero", st_data[0], 32'd0);
`ifdef MIPS_MC_RETIRE_PORT_EN
    k = fetch_idx(32'h08);
    chk("retire_2", (k < 0) ? 32'hDEAD_BEEF : t_rc[k], 32'd2);
    chk("retire_3", retire_count, 32'd3);
    chk("retire_pc_idle", {31'b0, retire_valid}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
